// File: rtl/floor_car_ctrl.sv
// Elevator car sequencer: owns the one-hot current/target floor registers that feed
// the floor comparator, and steps the car one floor at a time from the comparator result.
module floor_car_ctrl #(
  parameter int WIDTH         = 6,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_floor,
  output logic             req_ready,
  output logic             req_err,
  input  logic             cmp_greater,
  input  logic             cmp_lesser,
  input  logic             cmp_equal,
  output logic [WIDTH-1:0] cur_floor,
  output logic [WIDTH-1:0] tgt_floor,
  output logic             moving_up,
  output logic             moving_down,
  output logic             door_open,
  output logic             arrived
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [WIDTH-1:0] FLOOR0      = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_cur, w_cur_nxt;
  logic [WIDTH-1:0]   r_tgt, w_tgt_nxt;
  logic               r_pending, w_pending_nxt;
  logic               r_req_err, r_moving_up, r_moving_down, r_door_open, r_arrived;
  logic               w_accept, w_req_onehot;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - FLOOR0)) == '0);
  endfunction

  assign req_ready    = (r_state == S_IDLE) && !r_pending;
  assign w_accept     = req_valid && req_ready;
  assign w_req_onehot = is_onehot(req_floor);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cur_nxt     = r_cur;
    w_tgt_nxt     = r_tgt;
    w_pending_nxt = r_pending;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_req_onehot) begin
          w_tgt_nxt     = req_floor;
          w_pending_nxt = 1'b1;
        end else if (r_pending) begin
          // Ambiguous comparator output (none or several flags) keeps the car parked.
          case ({cmp_greater, cmp_lesser, cmp_equal})
            3'b001:  begin w_state_nxt = S_DOOR_OPEN; w_cnt_nxt = '0; end
            3'b010:  begin w_state_nxt = S_MOVE_UP;   w_cnt_nxt = '0; end
            3'b100:  begin w_state_nxt = S_MOVE_DOWN; w_cnt_nxt = '0; end
            default: ;
          endcase
        end
      end
      S_MOVE_UP: begin
        if (cmp_equal) begin
          w_state_nxt = S_DOOR_OPEN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TRAVEL_LAST) begin
          w_cnt_nxt = '0;
          if (r_cur[WIDTH-1]) begin
            w_state_nxt   = S_IDLE;
            w_pending_nxt = 1'b0;
          end else begin
            w_cur_nxt = r_cur << 1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_MOVE_DOWN: begin
        if (cmp_equal) begin
          w_state_nxt = S_DOOR_OPEN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TRAVEL_LAST) begin
          w_cnt_nxt = '0;
          if (r_cur[0]) begin
            w_state_nxt   = S_IDLE;
            w_pending_nxt = 1'b0;
          end else begin
            w_cur_nxt = r_cur >> 1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_DOOR_OPEN: begin
        if (r_cnt == DOOR_LAST) begin
          w_state_nxt   = S_IDLE;
          w_pending_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cur         <= FLOOR0;
      r_tgt         <= FLOOR0;
      r_pending     <= 1'b0;
      r_req_err     <= 1'b0;
      r_moving_up   <= 1'b0;
      r_moving_down <= 1'b0;
      r_door_open   <= 1'b0;
      r_arrived     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cur         <= w_cur_nxt;
      r_tgt         <= w_tgt_nxt;
      r_pending     <= w_pending_nxt;
      r_req_err     <= w_accept && !w_req_onehot;
      r_moving_up   <= (w_state_nxt == S_MOVE_UP);
      r_moving_down <= (w_state_nxt == S_MOVE_DOWN);
      r_door_open   <= (w_state_nxt == S_DOOR_OPEN);
      r_arrived     <= (w_state_nxt == S_DOOR_OPEN) && (r_state != S_DOOR_OPEN);
    end
  end

  assign cur_floor   = r_cur;
  assign tgt_floor   = r_tgt;
  assign req_err     = r_req_err;
  assign moving_up   = r_moving_up;
  assign moving_down = r_moving_down;
  assign door_open   = r_door_open;
  assign arrived     = r_arrived;

endmodule

// File: tb/tb_floor_car_ctrl.sv
// Directed bench for floor_car_ctrl with a behavioural floor comparator closing the loop.
module tb_floor_car_ctrl;

  localparam int W      = 6;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_floor = '0;
  logic         req_ready, req_err;
  logic         cmp_greater, cmp_lesser, cmp_equal;
  logic [W-1:0] cur_floor, tgt_floor;
  logic         moving_up, moving_down, door_open, arrived;

  int n_checks = 0;
  int n_errors = 0;

  floor_car_ctrl #(.WIDTH(W), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .req_err(req_err),
    .cmp_greater(cmp_greater), .cmp_lesser(cmp_lesser), .cmp_equal(cmp_equal),
    .cur_floor(cur_floor), .tgt_floor(tgt_floor),
    .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .arrived(arrived)
  );

  always #5 clk = ~clk;

  // One-hot codes order the same way as floor numbers, so a magnitude compare suffices.
  assign cmp_greater = (cur_floor > tgt_floor);
  assign cmp_lesser  = (cur_floor < tgt_floor);
  assign cmp_equal   = (cur_floor == tgt_floor);

  typedef struct {
    logic         rst_n;
    logic         vld;
    logic [W-1:0] floor;
    logic [W-1:0] e_cur;
    logic [W-1:0] e_tgt;
    logic         e_ready;
    logic         e_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic up, input logic dn,
                            input logic door, input logic arr);
    chk({tag, ".moving_up"},   32'(moving_up),   32'(up));
    chk({tag, ".moving_down"}, 32'(moving_down), 32'(dn));
    chk({tag, ".door_open"},   32'(door_open),   32'(door));
    chk({tag, ".arrived"},     32'(arrived),     32'(arr));
  endtask

  // Request dest from start; nmoves floors travelled; junk=1 offers 010000 while moving.
  task automatic trip(input string tag, input logic [W-1:0] start, input logic [W-1:0] dest,
                      input bit up, input int nmoves, input bit junk);
    logic [W-1:0] exp_cur;
    exp_cur   = start;
    req_valid = 1'b1;
    req_floor = dest;
    step();
    req_valid = 1'b0;
    chk({tag, ".tgt_latched"}, 32'(tgt_floor), 32'(dest));
    chk({tag, ".ready_low"},   32'(req_ready), 32'd0);
    if (nmoves > 0) begin
      step();
      chk_status({tag, ".move_start"}, up, !up, 1'b0, 1'b0);
      if (junk) begin
        req_valid = 1'b1;
        req_floor = 6'b010000;
      end
      for (int m = 0; m < nmoves; m++) begin
        for (int c = 1; c <= TRAVEL; c++) begin
          step();
          if (c == TRAVEL) exp_cur = up ? (exp_cur << 1) : (exp_cur >> 1);
          chk({tag, ".cur"}, 32'(cur_floor), 32'(exp_cur));
          chk({tag, ".dir"}, 32'(up ? moving_up : moving_down), 32'd1);
        end
      end
      req_valid = 1'b0;
    end
    step();
    chk_status({tag, ".arrive"}, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, ".arrive_cur"}, 32'(cur_floor), 32'(dest));
    chk({tag, ".arrive_tgt"}, 32'(tgt_floor), 32'(dest));
    for (int d = 1; d < DOOR; d++) begin
      step();
      chk({tag, ".door_hold"},   32'(door_open), 32'd1);
      chk({tag, ".arrived_off"}, 32'(arrived),   32'd0);
      chk({tag, ".ready_door"},  32'(req_ready), 32'd0);
    end
    step();
    chk({tag, ".door_closed"}, 32'(door_open), 32'd0);
    chk({tag, ".ready_back"},  32'(req_ready), 32'd1);
  endtask

  initial begin
    //            rst  vld  floor      e_cur      e_tgt      rdy  err
    vecs[0] = '{1'b0, 1'b0, 6'b000000, 6'b000001, 6'b000001, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 6'b000100, 6'b000001, 6'b000001, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 6'b000000, 6'b000001, 6'b000001, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 6'b000110, 6'b000001, 6'b000001, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 6'b000000, 6'b000001, 6'b000001, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 6'b000000, 6'b000001, 6'b000001, 1'b1, 1'b0};

    for (int i = 0; i < 6; i++) begin
      reset     = vecs[i].rst_n;
      req_valid = vecs[i].vld;
      req_floor = vecs[i].floor;
      step();
      chk($sformatf("vec%0d.cur", i),   32'(cur_floor), 32'(vecs[i].e_cur));
      chk($sformatf("vec%0d.tgt", i),   32'(tgt_floor), 32'(vecs[i].e_tgt));
      chk($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d.err", i),   32'(req_err),   32'(vecs[i].e_err));
      chk_status($sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    req_valid = 1'b0;

    trip("up",    6'b000001, 6'b000100, 1'b1, 2, 1'b1);
    trip("down",  6'b000100, 6'b000001, 1'b0, 2, 1'b0);
    trip("equal", 6'b000001, 6'b000001, 1'b1, 0, 1'b0);

    // Reset while travelling up, once the car has reached 001000.
    req_valid = 1'b1;
    req_floor = 6'b010000;
    step();
    req_valid = 1'b0;
    step();
    chk("rstmove.moving", 32'(moving_up), 32'd1);
    for (int c = 0; c < 3 * TRAVEL; c++) step();
    chk("rstmove.cur_before", 32'(cur_floor), 32'(6'b001000));
    chk("rstmove.still_up",   32'(moving_up), 32'd1);
    reset = 1'b0;
    step();
    chk("rstmove.cur",   32'(cur_floor), 32'(6'b000001));
    chk("rstmove.tgt",   32'(tgt_floor), 32'(6'b000001));
    chk("rstmove.ready", 32'(req_ready), 32'd1);
    chk_status("rstmove", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk("rstmove.idle_ready", 32'(req_ready), 32'd1);
    chk("rstmove.idle_up",    32'(moving_up), 32'd0);
    chk("rstmove.idle_cur",   32'(cur_floor), 32'(6'b000001));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
